// File: rtl/nco_pkg.sv
// Shared definitions for the NCO: quadrant encoding, pipeline depth and the
// elaboration-time quarter-wave sine table generator.
package nco_pkg;

  typedef enum logic [1:0] {
    Q_I   = 2'd0,
    Q_II  = 2'd1,
    Q_III = 2'd2,
    Q_IV  = 2'd3
  } quad_e;

  localparam int NCO_STAGES = 3;

  // pi in unsigned Q60 fixed point
  localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;

  // T[k] = round((2^(ow-1)-1) * sin(pi*(2k+1)/2^aw)), evaluated with a
  // fixed-point Taylor series so no real arithmetic reaches the netlist.
  function automatic int rom_entry(input int k, input int aw, input int ow);
    logic signed [127:0] x, x2, term, sum, amp;
    x    = (PI_Q60 * 128'(2 * k + 1)) >>> aw;
    x2   = (x * x) >>> 60;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = -(((term * x2) >>> 60) / 128'(2 * n * (2 * n + 1)));
      sum  = sum + term;
    end
    amp = (128'sd1 <<< (ow - 1)) - 128'sd1;
    return int'((amp * sum + (128'sd1 <<< 59)) >>> 60);
  endfunction

endpackage

// File: rtl/nco_qlut.sv
// Quarter-wave sine lookup: quadrant decode, ROM read, mirror and negate,
// three registered stages from table address to signed sample.
module nco_qlut
  import nco_pkg::*;
#(
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LUT_AW-1:0]       addr,
  output logic signed [OUT_W-1:0] sample
);

  localparam int IW    = LUT_AW - 2;
  localparam int DEPTH = 1 << IW;

  logic [DEPTH-1:0][OUT_W-1:0] rom;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam int TK = rom_entry(k, LUT_AW, OUT_W);
    assign rom[k] = OUT_W'(TK);
  end

  quad_e                    q1;
  logic [IW-1:0]            i1;
  logic [IW-1:0]            rd_idx;
  logic signed [OUT_W-1:0]  mag2;
  logic                     neg2;

  // quadrants II and IV walk the stored quarter backwards
  assign rd_idx = ((q1 == Q_II) || (q1 == Q_IV)) ? ~i1 : i1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q1     <= Q_I;
      i1     <= '0;
      mag2   <= '0;
      neg2   <= 1'b0;
      sample <= '0;
    end else begin
      q1     <= quad_e'(addr[LUT_AW-1 -: 2]);
      i1     <= addr[IW-1:0];
      mag2   <= rom[rd_idx];
      neg2   <= (q1 == Q_III) || (q1 == Q_IV);
      sample <= neg2 ? -mag2 : mag2;
    end
  end

endmodule

// File: rtl/nco_core.sv
// Numerically controlled oscillator: tunable phase accumulator plus offset
// feeding quarter-wave sine lookup. Define NCO_QUAD_EN for the cos_out path.
module nco_core
  import nco_pkg::*;
#(
  parameter int ACC_W  = 24,
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [ACC_W-1:0]        ftw_in,
  input  logic                    ftw_load,
  input  logic [ACC_W-1:0]        pofs_in,
  input  logic                    phase_clr,
  output logic signed [OUT_W-1:0] sine_out,
  output logic                    out_valid
`ifdef NCO_QUAD_EN
  ,
  output logic signed [OUT_W-1:0] cos_out
`endif
);

  logic [ACC_W-1:0]      acc, ftw, phase;
  logic [LUT_AW-1:0]     sin_addr;
  logic [NCO_STAGES:1]   vld_pipe;
  logic                  phase_lsb_unused;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      ftw      <= '0;
      vld_pipe <= '0;
    end else begin
      if (ftw_load) ftw <= ftw_in;
      if (phase_clr)  acc <= '0;
      else if (en)    acc <= acc + ftw;
      vld_pipe <= {vld_pipe[NCO_STAGES-1:1], en};
    end
  end

  assign phase     = acc + pofs_in;
  assign sin_addr  = phase[ACC_W-1 -: LUT_AW];
  assign out_valid = vld_pipe[NCO_STAGES];

  // fractional phase bits are truncated, not rounded
  assign phase_lsb_unused = ^phase[ACC_W-LUT_AW-1:0];

  nco_qlut #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_sin (
    .clk    (clk),
    .rst    (rst),
    .addr   (sin_addr),
    .sample (sine_out)
  );

`ifdef NCO_QUAD_EN
  // a quarter turn only touches the table-address bits
  localparam logic [LUT_AW-1:0] QTR = {2'b01, {(LUT_AW-2){1'b0}}};

  logic [LUT_AW-1:0] cos_addr;
  assign cos_addr = sin_addr + QTR;

  nco_qlut #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_cos (
    .clk    (clk),
    .rst    (rst),
    .addr   (cos_addr),
    .sample (cos_out)
  );
`endif

endmodule

// File: tb/tb_nco_core.sv
// Scoreboard bench for nco_core; define NCO_QUAD_EN to also check cos_out.
`timescale 1ns/1ps
module tb_nco_core;
  localparam int ACC_W  = 24;
  localparam int LUT_AW = 8;
  localparam int OUT_W  = 16;
  localparam int IW     = LUT_AW - 2;
  localparam logic [ACC_W-1:0] QTR = 24'h400000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, ftw_load = 1'b0, phase_clr = 1'b0;
  logic [ACC_W-1:0] ftw_in = '0, pofs_in = '0;
  logic signed [OUT_W-1:0] sine_out;
  logic out_valid;
`ifdef NCO_QUAD_EN
  logic signed [OUT_W-1:0] cos_out;
`endif

  nco_core #(.ACC_W(ACC_W), .LUT_AW(LUT_AW), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .ftw_in(ftw_in), .ftw_load(ftw_load),
    .pofs_in(pofs_in), .phase_clr(phase_clr), .sine_out(sine_out),
    .out_valid(out_valid)
`ifdef NCO_QUAD_EN
    , .cos_out(cos_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                    vld;
    logic signed [OUT_W-1:0] s;
    logic signed [OUT_W-1:0] c;
    int                      tag;
  } exp_t;

  exp_t sb[$];
  int cap_s[$], cap_c[$], cap2[$], cap3[$], cap4v[$], cap5[$];
  int checks = 0, fails = 0;
  int tbl[1<<IW];
  logic [ACC_W-1:0] acc_m, ftw_m;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic signed [OUT_W-1:0] ref_sample(input logic [ACC_W-1:0] p);
    logic [1:0] q;
    int i, m;
    q = p[ACC_W-1 -: 2];
    i = int'(p[ACC_W-3 -: IW]);
    m = q[0] ? tbl[(1<<IW)-1-i] : tbl[i];
    return OUT_W'(q[1] ? -m : m);
  endfunction

  // one clock cycle of stimulus; expected output pushed for 3 cycles later
  task automatic cyc(input logic e, input logic ld, input logic [ACC_W-1:0] fw,
                     input logic [ACC_W-1:0] po, input logic clr, input int tag);
    exp_t it;
    en = e; ftw_load = ld; ftw_in = fw; pofs_in = po; phase_clr = clr;
    it.vld = e;
    it.s   = ref_sample(acc_m + po);
    it.c   = ref_sample(acc_m + po + QTR);
    it.tag = tag;
    sb.push_back(it);
    if (clr) acc_m = '0;
    else if (e) acc_m = acc_m + ftw_m;
    if (ld) ftw_m = fw;
    @(posedge clk); #1;
  endtask

  task automatic release_rst();
    sb.delete();
    acc_m = '0;
    ftw_m = '0;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && sb.size() >= 4) begin
      e = sb.pop_front();
      check("out_valid", int'(out_valid), int'(e.vld));
      check("sine_out", int'(sine_out), int'(e.s));
`ifdef NCO_QUAD_EN
      check("cos_out", int'(cos_out), int'(e.c));
      if (e.tag == 1) cap_c.push_back(int'(cos_out));
`endif
      case (e.tag)
        1: cap_s.push_back(int'(sine_out));
        2: cap2.push_back(int'(sine_out));
        3: cap3.push_back(int'(sine_out));
        4: cap4v.push_back(int'(out_valid));
        5: cap5.push_back(int'(sine_out));
        default: ;
      endcase
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nlow, mism;
    for (int k = 0; k < (1<<IW); k++)
      tbl[k] = $rtoi($floor(32767.0 * $sin(3.141592653589793 * (2.0*k + 1.0) / 256.0) + 0.5));

    repeat (2) @(posedge clk);
    #1;
    check("reset_sine", int'(sine_out), 0);
    check("reset_valid", int'(out_valid), 0);
`ifdef NCO_QUAD_EN
    check("reset_cos", int'(cos_out), 0);
`endif
    release_rst();

    // basic stream, ftw = 1 table step per cycle
    cyc(1, 1, 24'h010000, '0, 0, 1);
    for (int n = 0; n < 260; n++) cyc(1, 0, '0, '0, 0, 1);

    // phase offset with ftw = 0
    cyc(1, 1, 24'h000000, '0, 1, 0);
    for (int n = 0; n < 4; n++) cyc(1, 0, '0, 24'h800000, 0, 2);
    for (int n = 0; n < 4; n++) cyc(1, 0, '0, 24'h000000, 0, 2);

    // clear together with a new tuning word mid-stream
    cyc(1, 1, 24'h010000, '0, 0, 0);
    for (int n = 0; n < 10; n++) cyc(1, 0, '0, '0, 0, 0);
    cyc(1, 1, 24'h020000, '0, 1, 0);
    for (int n = 0; n < 6; n++) cyc(1, 0, '0, '0, 0, 3);

    // en low for 5 cycles
    cyc(1, 0, '0, '0, 0, 4);
    for (int n = 0; n < 5; n++) cyc(0, 0, '0, '0, 0, 4);
    cyc(1, 0, '0, '0, 0, 4);
    for (int n = 0; n < 4; n++) cyc(1, 0, '0, '0, 0, 0);

    // asynchronous reset between edges
    #2 rst = 1'b0;
    #1;
    check("async_rst_sine", int'(sine_out), 0);
    check("async_rst_valid", int'(out_valid), 0);
`ifdef NCO_QUAD_EN
    check("async_rst_cos", int'(cos_out), 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    release_rst();
    for (int n = 0; n < 8; n++) cyc(1, 0, '0, '0, 0, 5);
    for (int n = 0; n < 5; n++) cyc(1, 0, '0, '0, 0, 0);

    check("s1_len", int'(cap_s.size() >= 258), 1);
    if (cap_s.size() >= 258) begin
      check("s1_first", cap_s[0], 402);
      check("s1_step1", cap_s[2], 1206);
      check("s1_peak63", cap_s[64], 32765);
      check("s1_peak64", cap_s[65], 32765);
      check("s1_half", cap_s[129], -402);
      check("s1_period", cap_s[257], 402);
    end
`ifdef NCO_QUAD_EN
    check("cos_len", int'(cap_c.size() >= 216), 1);
    if (cap_c.size() >= 216 && cap_s.size() >= 216) begin
      check("cos_first", cap_c[1], 32765);
      mism = 0;
      for (int n = 0; n < 150; n++) if (cap_c[1+n] != cap_s[1+n+64]) mism++;
      check("cos_shift64", mism, 0);
    end
`endif
    check("pofs_len", cap2.size(), 8);
    if (cap2.size() == 8) begin
      check("pofs_half", cap2[3], -402);
      check("pofs_zero", cap2[4], 402);
    end
    check("clr_len", cap3.size(), 6);
    if (cap3.size() == 6) begin
      check("clr_first", cap3[0], 402);
      check("clr_step2", cap3[1], 2009);
    end
    nlow = 0;
    foreach (cap4v[k]) if (cap4v[k] == 0) nlow++;
    check("en_low_cycles", nlow, 5);
    check("post_rst_len", cap5.size(), 8);
    if (cap5.size() == 8) check("post_rst_const", cap5[7], 402);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/nco_core.md
# nco_core

Parametrised numerically controlled oscillator: the successor to the fixed 8-bit table counter. A runtime-tunable phase accumulator with a phase-offset input drives a quarter-wave sine ROM through a 3-stage registered pipeline, producing signed samples with a valid strobe. It sits at the head of the signal chain and feeds the DAC/mixer datapath.

## Interface
- ACC_W, 24: phase accumulator width in bits; must be at least LUT_AW+2.
- LUT_AW, 8: full-wave table address width; 2^LUT_AW points per period, 2^(LUT_AW-2) stored.
- OUT_W, 16: signed output sample width.
- clk  in  1  sole clock; rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  accumulator advance enable.
- ftw_in  in  ACC_W  frequency tuning word.
- ftw_load  in  1  one-cycle strobe; captures ftw_in.
- pofs_in  in  ACC_W  phase offset, sampled every cycle.
- phase_clr  in  1  synchronous accumulator clear.
- sine_out  out  OUT_W  signed sine sample.
- cos_out  out  OUT_W  signed cosine sample; present only with NCO_QUAD_EN.
- out_valid  out  1  high when the sample outputs correspond to an enabled accumulator cycle.

## Operation
- Registers `acc` and `ftw` are ACC_W wide.
- ftw_load=1: `ftw` <= ftw_in. The new value is used by the accumulator from the following cycle.
- Accumulator priority, evaluated per cycle:
  - phase_clr=1: acc <= 0.
  - else en=1: acc <= acc + ftw (modulo 2^ACC_W, natural wrap).
  - else: acc holds.
- phase_clr and ftw_load in the same cycle: both take effect.
- Phase: p = acc + pofs_in, modulo 2^ACC_W.
- Quadrant q = p[ACC_W-1:ACC_W-2]. Index i = p[ACC_W-3:ACC_W-LUT_AW]. Lower bits are truncated; there is no rounding.
- ROM entry T[k] = round((2^(OUT_W-1)-1) * sin(2π(k+0.5)/2^LUT_AW)) for k = 0 .. 2^(LUT_AW-2)-1. All entries are positive.
- Output value by quadrant:
  - q=0: T[i]
  - q=1: T[~i]
  - q=2: -T[i]
  - q=3: -T[~i]
- Negation is two's complement. No overflow is possible because T is at most 2^(OUT_W-1)-1.
- The pipeline advances every cycle regardless of en. With en low, the output repeats the held phase.

## Timing
- Stage 1 registers q and i from the current acc and pofs_in.
- Stage 2 registers the ROM read.
- Stage 3 registers the sign-applied sample to the outputs.
- Latency is 3 cycles from an acc value to its sample on sine_out.
- out_valid is en delayed by 3 cycles. phase_clr does not affect out_valid.
- Reset asserted:
  - acc=0, ftw=0, all pipeline registers 0.
  - sine_out=0, cos_out=0, out_valid=0, immediately and asynchronously.
- Reset deassertion mid-stream: the first valid sample appears 3 cycles after the first en=1 edge.
- Wrap-around of acc is silent; phase continuity is preserved.

## Configuration
- NCO_QUAD_EN defined:
  - A second lookup path computes phase p + 2^(ACC_W-2), giving cos_out.
  - cos_out has the same 3-cycle latency and is cycle-aligned with sine_out.
- NCO_QUAD_EN undefined:
  - The cos_out port and its logic are absent.
  - sine_out behaviour is identical in both builds.

## Structure
- Package nco_pkg holds:
  - the quadrant encoding constants;
  - the ROM-generation function computing T[k] from LUT_AW and OUT_W at elaboration (no external include file).
- Sub-module nco_qlut holds stages 1–3: quadrant decode, ROM, mirror and negate.
  - nco_core instantiates it once, or twice under NCO_QUAD_EN.

## Test plan
- Reset then release; ftw_in=0x010000 with ftw_load, en=1 (ACC_W=24, LUT_AW=8, OUT_W=16) -> out_valid rises 3 cycles after en; samples run 402, …, 32765 at step 64, −402 at step 128; period is 256 cycles.
- Same stream with NCO_QUAD_EN -> cos_out first valid sample is 32765; cos_out equals sine_out shifted 64 samples.
- pofs_in=0x800000, ftw=0 -> constant −402; setting pofs_in=0 gives 402 three cycles later.
- phase_clr pulse together with ftw_load of 0x020000 mid-stream -> sample 3 cycles later is 402, then the output steps 2 table entries per cycle.
- en low for 5 cycles -> output frozen at the last sample; out_valid is low for exactly those 5 cycles, shifted by 3.
- Asynchronous reset asserted mid-stream, between clock edges -> all outputs are 0 immediately; after release, acc restarts from 0 and ftw=0, so the output stays constant at 402.
